// File: rtl/window_discriminator_fsm.sv
// Multi-window spike discriminator: sequences per-channel window bounds to the filter
// stage and pulses detect/reject once every window in the sequence has been resolved.
module window_discriminator_fsm #(
  parameter int NUM_WIN = 4
) (
  input  logic                   state_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   thrsh_in,
  input  logic                   inwin_in,
  input  logic [2:0]             num_win_cfg,
  input  logic [16*NUM_WIN-1:0]  win_start_cfg,
  input  logic [16*NUM_WIN-1:0]  win_stop_cfg,
  input  logic [NUM_WIN-1:0]     win_pol_cfg,
  input  logic [15:0]            refractory_cfg,
  output logic [15:0]            state_counter,
  output logic [15:0]            win_start_out,
  output logic [15:0]            win_stop_out,
  output logic [1:0]             win_idx,
  output logic                   detect,
  output logic                   reject,
  output logic [1:0]             fsm_state
);

  // state   | meaning
  // IDLE    | disabled, all outputs 0
  // ARMED   | waiting for a trigger crossing
  // TRACK   | stepping through windows, counting samples since trigger
  // REFRACT | dead time after a detect, crossings ignored
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_TRACK   = 2'd2,
    S_REFRACT = 2'd3
  } state_t;

  localparam logic [2:0] MAX_WIN = 3'(NUM_WIN);

  state_t             r_state;
  logic               r_thrsh_prev;
  logic               r_hit;
  logic [15:0]        r_start [NUM_WIN];
  logic [15:0]        r_stop  [NUM_WIN];
  logic [NUM_WIN-1:0] r_pol;
  logic [15:0]        r_refr;
  logic [1:0]         r_last;

  logic       w_xing;
  logic [1:0] w_cfg_last;
  logic [1:0] w_next_idx;
  logic       w_pol_k;
  logic       w_win_end;
  logic       w_hit_now;
  logic       w_forbid;

  assign w_xing     = thrsh_in & ~r_thrsh_prev;
  assign w_next_idx = win_idx + 2'd1;
  assign w_pol_k    = r_pol[win_idx];
  assign w_win_end  = state_counter >= r_stop[win_idx];
  assign w_hit_now  = r_hit | (w_xing & inwin_in & w_pol_k);
  assign w_forbid   = w_xing & inwin_in & ~w_pol_k;
  assign fsm_state  = r_state;

  always_comb begin
    w_cfg_last = 2'd0;
    if (num_win_cfg == 3'd0)
      w_cfg_last = 2'd0;
    else if (num_win_cfg > MAX_WIN)
      w_cfg_last = 2'(MAX_WIN - 3'd1);
    else
      w_cfg_last = 2'(num_win_cfg - 3'd1);
  end

  always_ff @(posedge state_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_thrsh_prev  <= 1'b1;
      r_hit         <= 1'b0;
      r_pol         <= '0;
      r_refr        <= 16'd0;
      r_last        <= 2'd0;
      state_counter <= 16'd0;
      win_start_out <= 16'd0;
      win_stop_out  <= 16'd0;
      win_idx       <= 2'd0;
      detect        <= 1'b0;
      reject        <= 1'b0;
      for (int k = 0; k < NUM_WIN; k++) begin
        r_start[k] <= 16'd0;
        r_stop[k]  <= 16'd0;
      end
    end else begin
      r_thrsh_prev <= thrsh_in;
      detect       <= 1'b0;
      reject       <= 1'b0;
      if (!enable) begin
        r_state       <= S_IDLE;
        r_hit         <= 1'b0;
        state_counter <= 16'd0;
        win_start_out <= 16'd0;
        win_stop_out  <= 16'd0;
        win_idx       <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARMED;

          S_ARMED: begin
            if (w_xing) begin
              for (int k = 0; k < NUM_WIN; k++) begin
                r_start[k] <= win_start_cfg[16*k +: 16];
                r_stop[k]  <= win_stop_cfg[16*k +: 16];
              end
              r_pol         <= win_pol_cfg;
              r_refr        <= refractory_cfg;
              r_last        <= w_cfg_last;
              r_hit         <= 1'b0;
              state_counter <= 16'd0;
              win_idx       <= 2'd0;
              win_start_out <= win_start_cfg[15:0];
              win_stop_out  <= win_stop_cfg[15:0];
              r_state       <= S_TRACK;
            end
          end

          S_TRACK: begin
            // Forbidden crossing and timeout take precedence over the window-end decision.
            if (w_forbid || state_counter == 16'hFFFF || (w_win_end && w_pol_k && !w_hit_now)) begin
              reject        <= 1'b1;
              r_hit         <= 1'b0;
              state_counter <= 16'd0;
              win_start_out <= 16'd0;
              win_stop_out  <= 16'd0;
              win_idx       <= 2'd0;
              r_state       <= S_ARMED;
            end else if (w_win_end && win_idx == r_last) begin
              detect        <= 1'b1;
              r_hit         <= 1'b0;
              state_counter <= 16'd0;
              win_start_out <= 16'd0;
              win_stop_out  <= 16'd0;
              win_idx       <= 2'd0;
              r_state       <= S_REFRACT;
            end else if (w_win_end) begin
              r_hit         <= 1'b0;
              win_idx       <= w_next_idx;
              win_start_out <= r_start[w_next_idx];
              win_stop_out  <= r_stop[w_next_idx];
              state_counter <= state_counter + 16'd1;
            end else begin
              r_hit         <= w_hit_now;
              state_counter <= state_counter + 16'd1;
            end
          end

          S_REFRACT: begin
            if (state_counter >= r_refr) begin
              state_counter <= 16'd0;
              r_state       <= S_ARMED;
            end else begin
              state_counter <= state_counter + 16'd1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_discriminator_fsm.sv
// Bench for window_discriminator_fsm: directed test-plan scenarios plus randomized
// sequences, checked against an outcome model built from window end counts.
module tb_window_discriminator_fsm;

  logic        state_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        thrsh_in = 1'b0;
  logic        inwin_in;
  logic [2:0]  num_win_cfg = 3'd1;
  logic [63:0] win_start_cfg = '0;
  logic [63:0] win_stop_cfg = '0;
  logic [3:0]  win_pol_cfg = '0;
  logic [15:0] refractory_cfg = '0;
  logic [15:0] state_counter, win_start_out, win_stop_out;
  logic [1:0]  win_idx, fsm_state;
  logic        detect, reject;

  int vectors = 0;
  int miscompares = 0;

  int st[4];
  int sp[4];
  bit pl[4];
  int nwin_cfg;
  int refr;
  bit s[256];
  int eff;
  int e_arr[4];

  window_discriminator_fsm #(.NUM_WIN(4)) dut (
    .state_clk(state_clk), .reset(reset), .enable(enable),
    .thrsh_in(thrsh_in), .inwin_in(inwin_in), .num_win_cfg(num_win_cfg),
    .win_start_cfg(win_start_cfg), .win_stop_cfg(win_stop_cfg),
    .win_pol_cfg(win_pol_cfg), .refractory_cfg(refractory_cfg),
    .state_counter(state_counter), .win_start_out(win_start_out),
    .win_stop_out(win_stop_out), .win_idx(win_idx), .detect(detect),
    .reject(reject), .fsm_state(fsm_state)
  );

  // Filter-stage emulation: window comparator on the block's own outputs.
  assign inwin_in = (state_counter >= win_start_out) && (state_counter < win_stop_out);

  always #5 state_clk = ~state_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge state_clk);
    #1;
  endtask

  task automatic drive_cfg();
    num_win_cfg    = 3'(nwin_cfg);
    refractory_cfg = 16'(refr);
    for (int k = 0; k < 4; k++) begin
      win_start_cfg[16*k +: 16] = 16'(st[k]);
      win_stop_cfg[16*k +: 16]  = 16'(sp[k]);
      win_pol_cfg[k]            = pl[k];
    end
  endtask

  task automatic clear_s();
    for (int i = 0; i < 256; i++) s[i] = 1'b0;
  endtask

  function automatic bit xing_at(int c);
    bit prev;
    prev = (c == 0) ? 1'b1 : s[c-1];
    return s[c] && !prev;
  endfunction

  // Window k occupies counts (e[k-1], e[k]] after the trigger, where e[k] is the first
  // count at or beyond its stop that follows the previous window's end.
  task automatic model(output int d, output bit det);
    int  e_prev, found;
    bit  done;
    eff    = (nwin_cfg == 0) ? 1 : ((nwin_cfg > 4) ? 4 : nwin_cfg);
    e_prev = -1;
    done   = 1'b0;
    det    = 1'b1;
    d      = 0;
    for (int k = 0; k < eff; k++) begin
      if (!done) begin
        e_arr[k] = (sp[k] > e_prev + 1) ? sp[k] : e_prev + 1;
        found = -1;
        for (int c = e_prev + 1; c <= e_arr[k]; c++)
          if (found < 0 && xing_at(c) && st[k] <= c && c < sp[k]) found = c;
        if (!pl[k] && found >= 0) begin
          d = found; det = 1'b0; done = 1'b1;
        end else if (pl[k] && found < 0) begin
          d = e_arr[k]; det = 1'b0; done = 1'b1;
        end
        e_prev = e_arr[k];
      end
    end
    if (!done) d = e_prev;
  endtask

  function automatic int kexp(int c);
    for (int k = 0; k < eff; k++)
      if (c <= e_arr[k]) return k;
    return eff - 1;
  endfunction

  task automatic run_seq(input bit poke);
    int d, k;
    bit det, ok;
    model(d, det);
    drive_cfg();
    enable = 1'b1;
    thrsh_in = 1'b0;
    step();
    step();
    vectors++;
    if (fsm_state !== 2'd1) begin
      miscompares++;
      $display("FAIL armed_before_trigger: state=%0d expected 1", fsm_state);
    end
    thrsh_in = 1'b1;
    step();
    ok = 1'b1;
    for (int c = 0; c <= d; c++) begin
      k = kexp(c);
      vectors++;
      if (fsm_state !== 2'd2 || state_counter !== 16'(c) || win_idx !== 2'(k) ||
          win_start_out !== 16'(st[k]) || win_stop_out !== 16'(sp[k]) ||
          detect !== 1'b0 || reject !== 1'b0) begin
        miscompares++;
        ok = 1'b0;
        $display("FAIL track c=%0d: state=%0d cnt=%0d idx=%0d start=%0d stop=%0d det=%b rej=%b, expected state=2 cnt=%0d idx=%0d start=%0d stop=%0d no pulse",
                 c, fsm_state, state_counter, win_idx, win_start_out, win_stop_out,
                 detect, reject, c, k, st[k], sp[k]);
      end
      if (!ok) break;
      thrsh_in = s[c];
      if (poke && c == 3) begin
        win_start_cfg  = {$urandom, $urandom};
        win_stop_cfg   = {$urandom, $urandom};
        win_pol_cfg    = 4'($urandom);
        num_win_cfg    = 3'($urandom);
        refractory_cfg = 16'($urandom);
      end
      step();
    end
    if (!ok) begin
      enable = 1'b0;
      thrsh_in = 1'b0;
      step();
      return;
    end
    vectors++;
    if (detect !== det || reject !== !det || fsm_state !== (det ? 2'd3 : 2'd1) ||
        state_counter !== 16'd0 || win_start_out !== 16'd0) begin
      miscompares++;
      $display("FAIL outcome after count %0d: det=%b rej=%b state=%0d cnt=%0d start=%0d, expected det=%b rej=%b state=%0d cnt=0 start=0",
               d, detect, reject, fsm_state, state_counter, win_start_out,
               det, !det, det ? 3 : 1);
    end
    thrsh_in = 1'b0;
    if (det) begin
      for (int j = 0; j <= refr; j++) begin
        thrsh_in = (j < refr) ? 1'($urandom) : 1'b0;
        step();
        vectors++;
        if (j + 1 <= refr) begin
          if (fsm_state !== 2'd3 || state_counter !== 16'(j + 1) || detect !== 1'b0 || reject !== 1'b0) begin
            miscompares++;
            $display("FAIL refract j=%0d: state=%0d cnt=%0d det=%b rej=%b, expected state=3 cnt=%0d no pulse",
                     j + 1, fsm_state, state_counter, detect, reject, j + 1);
          end
        end else begin
          if (fsm_state !== 2'd1 || state_counter !== 16'd0) begin
            miscompares++;
            $display("FAIL refract_exit after %0d cycles: state=%0d cnt=%0d, expected state=1 cnt=0",
                     refr + 1, fsm_state, state_counter);
          end
        end
      end
    end else begin
      step();
      vectors++;
      if (reject !== 1'b0 || detect !== 1'b0 || fsm_state !== 2'd1) begin
        miscompares++;
        $display("FAIL reject_width: det=%b rej=%b state=%0d, expected no pulse state=1",
                 detect, reject, fsm_state);
      end
    end
  endtask

  task automatic set_single(input int a, input int b, input bit p);
    nwin_cfg = 1;
    for (int k = 0; k < 4; k++) begin
      st[k] = 0; sp[k] = 0; pl[k] = 1'b0;
    end
    st[0] = a; sp[0] = b; pl[0] = p;
    refr = 5;
    clear_s();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; thrsh_in = 1'b1;
    step(); step(); step();
    vectors++;
    if (state_counter !== 16'd0 || win_start_out !== 16'd0 || win_stop_out !== 16'd0 ||
        win_idx !== 2'd0 || detect !== 1'b0 || reject !== 1'b0 || fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: cnt=%0d start=%0d stop=%0d idx=%0d det=%b rej=%b state=%0d, expected all 0",
               state_counter, win_start_out, win_stop_out, win_idx, detect, reject, fsm_state);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (fsm_state !== 2'd1 || state_counter !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_high_thrsh cycle %0d: state=%0d cnt=%0d, expected state=1 cnt=0",
                 i, fsm_state, state_counter);
      end
    end
  endtask

  task automatic test_single_window();
    set_single(10, 20, 1'b1);
    s[15] = 1'b1;
    run_seq(1'b0);
  endtask

  task automatic test_missed_window();
    set_single(10, 20, 1'b1);
    run_seq(1'b0);
  endtask

  task automatic test_forbidden_window();
    set_single(5, 8, 1'b0);
    s[6] = 1'b1;
    run_seq(1'b0);
    set_single(5, 8, 1'b0);
    s[8] = 1'b1;
    run_seq(1'b0);
  endtask

  task automatic test_three_windows();
    set_single(10, 20, 1'b1);
    nwin_cfg = 3;
    st[1] = 30; sp[1] = 40; pl[1] = 1'b1;
    st[2] = 50; sp[2] = 60; pl[2] = 1'b1;
    refr = 100;
    s[12] = 1'b1; s[35] = 1'b1; s[55] = 1'b1;
    run_seq(1'b0);
  endtask

  task automatic test_shadow_config();
    set_single(10, 20, 1'b1);
    s[15] = 1'b1;
    run_seq(1'b1);
  endtask

  task automatic test_enable_drop();
    set_single(10, 20, 1'b1);
    drive_cfg();
    enable = 1'b1; thrsh_in = 1'b0;
    step(); step();
    thrsh_in = 1'b1;
    step();
    thrsh_in = 1'b0;
    for (int c = 0; c < 15; c++) step();
    vectors++;
    if (state_counter !== 16'd15 || fsm_state !== 2'd2) begin
      miscompares++;
      $display("FAIL enable_drop_pre: cnt=%0d state=%0d, expected cnt=15 state=2",
               state_counter, fsm_state);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (fsm_state !== 2'd0 || state_counter !== 16'd0 || win_start_out !== 16'd0 ||
          win_stop_out !== 16'd0 || win_idx !== 2'd0 || detect !== 1'b0 || reject !== 1'b0) begin
        miscompares++;
        $display("FAIL enable_drop cycle %0d: state=%0d cnt=%0d start=%0d stop=%0d idx=%0d det=%b rej=%b, expected all 0",
                 i, fsm_state, state_counter, win_start_out, win_stop_out, win_idx, detect, reject);
      end
    end
    enable = 1'b1;
    step();
    vectors++;
    if (fsm_state !== 2'd1) begin
      miscompares++;
      $display("FAIL enable_restore: state=%0d expected 1", fsm_state);
    end
  endtask

  task automatic test_random();
    int density;
    for (int n = 0; n < 40; n++) begin
      nwin_cfg = int'($urandom_range(0, 7));
      density  = int'($urandom_range(5, 40));
      for (int k = 0; k < 4; k++) begin
        st[k] = k * 30 + int'($urandom_range(0, 15));
        sp[k] = st[k] + int'($urandom_range(0, 14)) - 2;
        if (sp[k] < 0) sp[k] = 0;
        pl[k] = 1'($urandom);
      end
      refr = int'($urandom_range(0, 20));
      for (int c = 0; c < 256; c++) s[c] = (int'($urandom_range(0, 99)) < density);
      run_seq(1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_missed_window();
    test_forbidden_window();
    test_three_windows();
    test_shadow_config();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_discriminator_fsm.md
# window_discriminator_fsm

Multi-window spike discriminator that sequences the per-channel window comparison in the analog output path. Clocked once per sample by `state_clk`. It consumes the filter stage's threshold-crossing flag (`thrsh_out`) and window flag (`fsm_inwin_out`). It produces the sample counter and the active window bounds that drive the filter stage's `fsm_state_counter_in`, `fsm_start_win_in` and `fsm_stop_win_in`. It emits one-cycle detect and reject pulses for downstream digital outputs.

## Interface
- NUM_WIN, 4: number of window slots implemented (1..4).
- state_clk  in  1  sample-rate clock.
- reset  in  1  reset, synchronous, active-high; clock state_clk.
- enable  in  1  1 = discriminator active; 0 = forced to IDLE.
- thrsh_in  in  1  threshold comparator flag from the filter stage.
- inwin_in  in  1  window comparator flag from the filter stage, computed combinationally from this block's registered outputs.
- num_win_cfg  in  3  windows used per sequence; 0 is treated as 1; values above NUM_WIN are clamped to NUM_WIN.
- win_start_cfg  in  16*NUM_WIN  window start counts; slot k is bits [16k+15:16k].
- win_stop_cfg  in  16*NUM_WIN  window stop counts (exclusive).
- win_pol_cfg  in  NUM_WIN  1 = a crossing is required in the window; 0 = a crossing in the window is forbidden.
- refractory_cfg  in  16  dead time after a detect.
- state_counter  out  16  samples since the trigger, or since the detect during REFRACT; to filter `fsm_state_counter_in`.
- win_start_out  out  16  active window start; to filter `fsm_start_win_in`.
- win_stop_out  out  16  active window stop; to filter `fsm_stop_win_in`.
- win_idx  out  2  index of the active window.
- detect  out  1  one-cycle pulse: all windows satisfied.
- reject  out  1  one-cycle pulse: sequence failed.
- fsm_state  out  2  current state: IDLE=0, ARMED=1, TRACK=2, REFRACT=3.

## Operation
- Crossing event: `xing = thrsh_in & ~thrsh_prev`. `thrsh_prev` is registered every cycle and resets to 1, so a level that is already high at reset is not treated as an edge.
- IDLE: all outputs are 0. Moves to ARMED when enable=1.
- ARMED: on `xing`, the block latches all *_cfg inputs into shadow registers, clears state_counter and win_idx, and moves to TRACK. The trigger crossing does not count toward window 0.
- TRACK:
  - state_counter increments each cycle and saturates at 16'hFFFF.
  - win_start_out and win_stop_out come from shadow slot win_idx.
  - If `xing & inwin_in` and pol[k]=1, set hit flag. If pol[k]=0, the block pulses reject and moves to ARMED.
  - Window end is state_counter ≥ stop[k]:
    - pol[k]=1 and hit flag clear: reject, move to ARMED.
    - Otherwise, if k is the last window: pulse detect, clear state_counter, move to REFRACT.
    - Otherwise: increment win_idx and clear the hit flag.
  - If state_counter reaches 16'hFFFF while in TRACK, the block rejects (timeout).
  - An empty window (stop ≤ start) with pol=1 always rejects. With pol=0 it always passes.
- REFRACT: crossings are ignored. state_counter counts up from 0. The block leaves when state_counter ≥ shadow refractory, so REFRACT lasts refractory+1 cycles. It then goes to ARMED, or to IDLE if enable=0.
- Outside TRACK, win_start_out = win_stop_out = 0, so inwin_in is 0.
- Config changes during TRACK or REFRACT have no effect; only the shadow copies are used.

## Timing
- All outputs are registered. Reset value is 0 for every output. Reset also sets the hit flag to 0 and thrsh_prev to 1.
- Reset or enable=0 while in any non-IDLE state: IDLE on the next edge. No detect or reject pulse is issued.
- detect and reject are high for exactly one cycle: the first cycle of the destination state. They are never high together.
- Event-to-pulse latency is 1 cycle. The cycle in which a qualifying inwin_in/xing or end condition is seen is followed by the pulse on the next cycle.
- A crossing on the cycle where state_counter = stop[k] is outside the window, because inwin_in = 0 at that count.
- Trigger-to-TRACK latency is 1 cycle. In the first TRACK cycle, state_counter = 0.

## Test plan
- Single required window: num_win=1, win0=[10,20), pol=1. Trigger edge, then a crossing at count 15 -> detect for one cycle when state_counter would be 21 (the cycle after count 20); fsm_state=3.
- Missed window: same config, no crossing after the trigger -> reject for one cycle after count 20; fsm_state=1; no detect.
- Forbidden window: win0=[5,8), pol=0; crossing at count 6 -> reject on the next cycle. Crossing at count 8 instead -> no reject, detect after count 8.
- Three windows [10,20),[30,40),[50,60), all pol=1, crossings at counts 12, 35, 55, refractory=100 -> win_idx steps 0→1→2, detect after count 60. Crossings during REFRACT are ignored. ARMED is re-entered after 101 cycles.
- Reset robustness:
  - Hold thrsh_in=1 through reset release -> no trigger.
  - Assert enable=0 at count 15 in TRACK -> IDLE next cycle, all outputs 0, no pulse.
- Shadow config: change win_stop_cfg from 20 to 5 mid-TRACK -> window still ends at count 20.
